// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states, lane count.
package dmem_lsu_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // An illegal size counts as misaligned so one check covers both error causes.
  function automatic logic req_bad(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word store data into a read word.
module dmem_lsu_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0]       mem_data,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [LANE_W-1:0] lane,
  input  logic [15:0]       wr_data,
  output logic [31:0]       ld_data,
  output logic [31:0]       st_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = mem_data[{lane, 3'b000} +: 8];
    half_v  = lane[1] ? mem_data[31:16] : mem_data[15:0];
    ld_data = mem_data;
    st_data = mem_data;
    case (size)
      SZ_B: begin
        ld_data = {{24{sext & byte_v[7]}}, byte_v};
        st_data[{lane, 3'b000} +: 8] = wr_data[7:0];
      end
      SZ_H: begin
        ld_data = {{16{sext & half_v[15]}}, half_v};
        if (lane[1]) st_data[31:16] = wr_data;
        else         st_data[15:0]  = wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-only data memory; sub-word stores are read-modify-write.
// state  | meaning
// IDLE   | waiting for Req; latches the request and screens alignment
// ACCESS | memory addressed; load captured, word store written, or sub-word merge built
// WRITE  | merged word written back for a byte/half store
// RESP   | one-cycle Done pulse with Err
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Req,
  input  logic                     Wr,
  input  logic [1:0]               Size,
  input  logic                     Sext,
  input  logic [ADDRESS_WIDTH+1:0] Addr,
  input  logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    RdData,
  output logic                     Done,
  output logic                     Err,
  output logic                     Busy,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic                     MemWrite
);

  state_e                   state_q, state_d;
  logic                     wr_q, wr_d;
  logic [1:0]               size_q, size_d;
  logic                     sext_q, sext_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    ld_data, st_data;

  dmem_lsu_lane_align u_align (
    .mem_data (MemData),
    .size     (size_q),
    .sext     (sext_q),
    .lane     (lane_q),
    .wr_data  (wdata_q[15:0]),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_write_d = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          wr_d       = Wr;
          size_d     = Size;
          sext_d     = Sext;
          lane_d     = Addr[1:0];
          wdata_d    = WrData;
          mem_addr_d = Addr[ADDRESS_WIDTH+1:2];
          if (req_bad(Size, Addr[1:0])) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            // Word store is raised here so the memory samples it at the end of ACCESS.
            if (Wr && Size == SZ_W) begin
              mem_write_d = 1'b1;
              mem_wdata_d = WrData;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (!wr_q) begin
          rd_data_d = ld_data;
          state_d   = ST_RESP;
          done_d    = 1'b1;
        end else if (size_q == SZ_W) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          mem_wdata_d = st_data;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        done_d  = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      size_q      <= SZ_B;
      sext_q      <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Gating with Rst_n keeps a reset landing mid-write from corrupting the target word.
  assign MemWrite     = mem_write_q & Rst_n;
  assign MemWriteData = mem_wdata_q;
  assign MemAddress   = mem_addr_q;
  assign RdData       = rd_data_q;
  assign Done         = done_q;
  assign Err          = err_q;
  assign Busy         = (state_q != ST_IDLE);

endmodule
